// File: rtl/ucode_loader.sv
// Assembles little-endian 8-byte groups from the debug/boot byte stream into upgm_t words
// and writes them to microcode RAM. Define UCODE_LOADER_CHECKSUM_EN for a trailing checksum byte.
module ucode_loader #(
    parameter int UADDR_WIDTH    = 11,
    parameter int WORD_BITS      = 62,
    parameter int BYTES_PER_WORD = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [UADDR_WIDTH-1:0] start_uaddr,
    input  logic [UADDR_WIDTH:0]   word_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_data,
    output logic                   wr_en,
    output logic [UADDR_WIDTH-1:0] wr_uaddr,
    output logic [WORD_BITS-1:0]   wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   error
);
    localparam int CNT_W     = UADDR_WIDTH + 1;
    localparam int IDX_W     = $clog2(BYTES_PER_WORD);
    localparam int LAST_BITS = WORD_BITS - 8 * (BYTES_PER_WORD - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        WRITE = 3'd2,
`ifdef UCODE_LOADER_CHECKSUM_EN
        CHECK = 3'd3,
`endif
        ERR   = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [UADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]       remain_q, remain_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [WORD_BITS-1:0]   asm_q, asm_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
`ifdef UCODE_LOADER_CHECKSUM_EN
    logic [7:0]             sum_q, sum_d;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            idx_q    <= '0;
            asm_q    <= '0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef UCODE_LOADER_CHECKSUM_EN
            sum_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef UCODE_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        done_d   = 1'b0;
        error_d  = error_q;
`ifdef UCODE_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
`endif
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = start_uaddr;
                    remain_d = word_count;
                    idx_d    = '0;
                    error_d  = 1'b0;
`ifdef UCODE_LOADER_CHECKSUM_EN
                    sum_d    = '0;
`endif
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RECV;
                    end
                end
            end

            RECV: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef UCODE_LOADER_CHECKSUM_EN
                    sum_d = sum_q + in_data;
`endif
                    for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            asm_d[8*k +: 8] = in_data;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        // Top byte carries only the upper upgm_t bits; the rest is reserved.
                        asm_d[WORD_BITS-1 -: LAST_BITS] = in_data[LAST_BITS-1:0];
                        idx_d = '0;
                        if ((in_data >> LAST_BITS) != 8'd0) begin
                            state_d = ERR;
                            error_d = 1'b1;
                        end else begin
                            state_d = WRITE;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end

            WRITE: begin
                busy     = 1'b1;
                wr_en    = 1'b1;
                addr_d   = addr_q + 1'b1;
                remain_d = remain_q - 1'b1;
                if (remain_q == CNT_W'(1)) begin
`ifdef UCODE_LOADER_CHECKSUM_EN
                    state_d = CHECK;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = RECV;
                end
            end

`ifdef UCODE_LOADER_CHECKSUM_EN
            CHECK: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    // Valid load: all data bytes plus this byte sum to zero mod 256.
                    if (8'(sum_q + in_data) == 8'd0) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif

            ERR: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_uaddr = wr_en ? addr_q : '0;
    assign wr_data  = wr_en ? asm_q : '0;
    assign done     = done_q;
    assign error    = error_q;

endmodule
